signal_lamp_driver: RTL and testbench
=====================================

# signal_lamp_driver

Downstream stage of the traffic light controller: takes the controller's active-side code and R/G/Y phase outputs and drives the physical lamps, 3 per side for 4 sides. Adds safety supervision. The block enforces an all-red start-up interval. It checks every input sample for legality and falls back to flashing-yellow mode after persistent illegal inputs. Instantiated in the top level between the controller outputs and the lamp pins.

## Interface
- INIT_RED, 8: all-red cycles after reset or fault recovery (≥2)
- FAULT_CYCLES, 3: consecutive illegal samples that trigger FLASH (≥1)
- FLASH_HALF, 50: cycles per half-period of the flashing yellow (≥1)
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high
- at_side  in  4  active side from controller, one-hot or all-zero
- R, G, Y  in  1 each  phase of the active side
- fault_clr  in  1  operator request to leave FLASH
- lamp_red, lamp_yellow, lamp_green  out  4 each  per-side lamp drives, bit i = side i, registered
- mode  out  2  INIT=0, NORMAL=1, FLASH=2
- fault  out  1  high while in FLASH
- fault_count  out  8  number of FLASH entries, saturates at 255

## Operation
- Legal sample: either (at_side one-hot AND exactly one of R/G/Y) OR (at_side==0 AND R AND !G AND !Y).
- Reset values:
  - mode=INIT, lamp_red=4'hF, lamp_yellow=0, lamp_green=0.
  - fault=0, fault_count=0; internal counters 0.
- INIT:
  - All lamps red. Inputs are ignored.
  - cnt increments each cycle. When cnt==INIT_RED-1, go to NORMAL and clear cnt.
- NORMAL, legal sample:
  - lamp_green[i]=at_side[i]&G; lamp_yellow[i]=at_side[i]&Y; lamp_red[i]=!(green|yellow).
  - bad_cnt cleared.
- NORMAL, illegal sample:
  - Lamps hold their previous values; bad_cnt increments.
  - If bad_cnt==FAULT_CYCLES-1, the state goes to FLASH on this edge. Lamps are loaded red=0, green=0, yellow=4'hF; blink=1 and flash_cnt=0; fault_count increments unless it is 255.
- FLASH:
  - lamp_red=0, lamp_green=0, lamp_yellow={4{blink}}.
  - flash_cnt wraps at FLASH_HALF-1, and blink toggles on the wrap.
  - fault=1.
- Exit FLASH: requires fault_clr=1 AND a legal sample in the same cycle. The state then goes to INIT (cnt=0, all red, bad_cnt=0). fault_clr with an illegal sample is ignored.
- fault_clr has no effect outside FLASH.
- Once in FLASH, the block stays there regardless of input legality until a valid exit.
- Reset asserted in any state returns everything to reset values at the next edge. fault_count is cleared only by reset.

## Timing
- Lamp latency in NORMAL: 1 cycle; inputs sampled at edge n appear on the lamps after edge n.
- After reset is released, call the edges e1, e2, …:
  - mode becomes NORMAL at e(INIT_RED).
  - The first input-driven lamp update is at e(INIT_RED+1). Lamps are all red through e(INIT_RED).
- Fault: the FAULT_CYCLES-th consecutive illegal sample puts mode=FLASH, yellow on, at that same edge. A single legal sample in between restarts the count.
- Flash waveform: yellow is on for FLASH_HALF cycles, then off for FLASH_HALF cycles, starting on at FLASH entry.
- Recovery: from the fault_clr edge, all red for INIT_RED cycles, then NORMAL exactly as after reset.

## Structure
- Package lamp_pkg holds:
  - the mode enum (INIT/NORMAL/FLASH) and a NUM_SIDES=4 constant;
  - the function is_legal(at_side, R, G, Y).
- Counter widths are $clog2 of their parameters, at least 1 bit.
- One sub-module, blink_gen (clk, reset, restart, blink), holds flash_cnt and blink. It is restarted on FLASH entry.
- Everything else (mode FSM, INIT counter, bad_cnt, lamp registers, fault_count) stays in signal_lamp_driver.

## Test plan
- Reset, then legal input at_side=4'b0001, G=1: lamps 4'hF red for 8 cycles; mode=1 at e8; at e9 lamp_green=4'b0001 and lamp_red=4'b1110.
- In NORMAL, at_side=4'b0100, Y=1, then at_side=0 with R=1: lamp_yellow=4'b0100 for one cycle, then lamp_red=4'hF; fault stays 0.
- Drive 2 illegal samples (at_side=4'b0011), 1 legal, then 2 illegal: lamps hold throughout the illegal samples; no FLASH entry; bad_cnt restarts after the legal sample.
- Drive 3 consecutive samples with G=1 and Y=1: FLASH entered on the 3rd edge, fault=1, fault_count=1; yellow 4'hF for 50 cycles, then 0 for 50 cycles, repeating.
- In FLASH, pulse fault_clr with an illegal sample: block stays in FLASH. Pulse fault_clr with a legal sample: mode=INIT, all red for 8 cycles, then NORMAL; fault_count stays 1.
- Assert reset for one cycle mid-FLASH: next edge mode=INIT, lamp_red=4'hF, fault=0, fault_count=0.

Source files
------------

// File: rtl/lamp_pkg.sv
// Shared types and helpers for the signal lamp driver: mode encoding, side count,
// and the input-legality check applied to every controller sample.
package lamp_pkg;

  localparam int NUM_SIDES = 4;

  typedef enum logic [1:0] {
    INIT   = 2'd0,
    NORMAL = 2'd1,
    FLASH  = 2'd2
  } mode_e;

  // Legal: one side active with exactly one phase, or no side active with red only.
  function automatic logic is_legal(input logic [NUM_SIDES-1:0] at_side,
                                    input logic R, input logic G, input logic Y);
    logic side_onehot;
    logic one_phase;
    side_onehot = (at_side != '0) && ((at_side & (at_side - 1'b1)) == '0);
    one_phase   = ({R, G, Y} == 3'b100) || ({R, G, Y} == 3'b010) || ({R, G, Y} == 3'b001);
    return (side_onehot && one_phase) || ((at_side == '0) && R && !G && !Y);
  endfunction

endpackage

// File: rtl/signal_lamp_driver_blink_gen.sv
// Flashing-yellow timebase: blink toggles every FLASH_HALF cycles and restarts
// high with a zeroed counter whenever restart is asserted.
module blink_gen #(
  parameter int FLASH_HALF = 50
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic blink
);

  localparam int FW = (FLASH_HALF > 1) ? $clog2(FLASH_HALF) : 1;

  logic [FW-1:0] flash_cnt_q, flash_cnt_d;
  logic          blink_q, blink_d;

  always_comb begin
    flash_cnt_d = flash_cnt_q;
    blink_d     = blink_q;
    if (restart) begin
      flash_cnt_d = '0;
      blink_d     = 1'b1;
    end else if (flash_cnt_q == FW'(FLASH_HALF - 1)) begin
      flash_cnt_d = '0;
      blink_d     = ~blink_q;
    end else begin
      flash_cnt_d = flash_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      flash_cnt_q <= '0;
      blink_q     <= 1'b0;
    end else begin
      flash_cnt_q <= flash_cnt_d;
      blink_q     <= blink_d;
    end
  end

  assign blink = blink_q;

endmodule

// File: rtl/signal_lamp_driver.sv
// Lamp driver with safety supervision: all-red start-up, per-sample legality check,
// fallback to flashing yellow after persistent illegal inputs, operator-cleared recovery.
module signal_lamp_driver
  import lamp_pkg::*;
#(
  parameter int INIT_RED     = 8,
  parameter int FAULT_CYCLES = 3,
  parameter int FLASH_HALF   = 50
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_SIDES-1:0] at_side,
  input  logic                 R,
  input  logic                 G,
  input  logic                 Y,
  input  logic                 fault_clr,
  output logic [NUM_SIDES-1:0] lamp_red,
  output logic [NUM_SIDES-1:0] lamp_yellow,
  output logic [NUM_SIDES-1:0] lamp_green,
  output logic [1:0]           mode,
  output logic                 fault,
  output logic [7:0]           fault_count
);

  localparam int CW = (INIT_RED > 1) ? $clog2(INIT_RED) : 1;
  localparam int BW = (FAULT_CYCLES > 1) ? $clog2(FAULT_CYCLES) : 1;

  mode_e                mode_q, mode_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [BW-1:0]        bad_cnt_q, bad_cnt_d;
  logic [NUM_SIDES-1:0] red_q, red_d, yellow_q, yellow_d, green_q, green_d;
  logic [7:0]           fault_count_q, fault_count_d;
  logic                 legal;
  logic                 flash_entry;
  logic                 blink;

  assign legal = is_legal(at_side, R, G, Y);

  blink_gen #(.FLASH_HALF(FLASH_HALF)) u_blink_gen (
    .clk     (clk),
    .reset   (reset),
    .restart (flash_entry),
    .blink   (blink)
  );

  always_comb begin
    mode_d        = mode_q;
    cnt_d         = cnt_q;
    bad_cnt_d     = bad_cnt_q;
    red_d         = red_q;
    yellow_d      = yellow_q;
    green_d       = green_q;
    fault_count_d = fault_count_q;
    flash_entry   = 1'b0;
    case (mode_q)
      INIT: begin
        red_d    = '1;
        yellow_d = '0;
        green_d  = '0;
        if (cnt_q == CW'(INIT_RED - 1)) begin
          mode_d = NORMAL;
          cnt_d  = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      NORMAL: begin
        if (legal) begin
          green_d   = at_side & {NUM_SIDES{G}};
          yellow_d  = at_side & {NUM_SIDES{Y}};
          red_d     = ~((at_side & {NUM_SIDES{G}}) | (at_side & {NUM_SIDES{Y}}));
          bad_cnt_d = '0;
        end else if (bad_cnt_q == BW'(FAULT_CYCLES - 1)) begin
          mode_d      = FLASH;
          red_d       = '0;
          green_d     = '0;
          yellow_d    = '1;
          bad_cnt_d   = '0;
          flash_entry = 1'b1;
          if (fault_count_q != 8'hFF) fault_count_d = fault_count_q + 8'd1;
        end else begin
          bad_cnt_d = bad_cnt_q + 1'b1;
        end
      end
      FLASH: begin
        // Only a clear request paired with a sane input sample is trusted.
        if (fault_clr && legal) begin
          mode_d    = INIT;
          cnt_d     = '0;
          bad_cnt_d = '0;
          red_d     = '1;
          yellow_d  = '0;
          green_d   = '0;
        end
      end
      default: mode_d = INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mode_q        <= INIT;
      cnt_q         <= '0;
      bad_cnt_q     <= '0;
      red_q         <= '1;
      yellow_q      <= '0;
      green_q       <= '0;
      fault_count_q <= '0;
    end else begin
      mode_q        <= mode_d;
      cnt_q         <= cnt_d;
      bad_cnt_q     <= bad_cnt_d;
      red_q         <= red_d;
      yellow_q      <= yellow_d;
      green_q       <= green_d;
      fault_count_q <= fault_count_d;
    end
  end

  // In FLASH the yellow drive follows the blink flop directly so it toggles on the wrap edge.
  assign lamp_yellow = (mode_q == FLASH) ? {NUM_SIDES{blink}} : yellow_q;
  assign lamp_red    = red_q;
  assign lamp_green  = green_q;
  assign mode        = mode_q;
  assign fault       = (mode_q == FLASH);
  assign fault_count = fault_count_q;

endmodule

// File: tb/tb_signal_lamp_driver.sv
// Directed bench for signal_lamp_driver: start-up, normal drive, illegal-input filtering,
// flash entry/waveform, recovery and reset, all with hand-computed expectations.
module tb_signal_lamp_driver;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] at_side;
  logic       R, G, Y;
  logic       fault_clr;
  logic [3:0] lamp_red, lamp_yellow, lamp_green;
  logic [1:0] mode;
  logic       fault;
  logic [7:0] fault_count;

  int n_chk  = 0;
  int n_fail = 0;

  signal_lamp_driver dut (
    .clk         (clk),
    .reset       (reset),
    .at_side     (at_side),
    .R           (R),
    .G           (G),
    .Y           (Y),
    .fault_clr   (fault_clr),
    .lamp_red    (lamp_red),
    .lamp_yellow (lamp_yellow),
    .lamp_green  (lamp_green),
    .mode        (mode),
    .fault       (fault),
    .fault_count (fault_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] s, input logic r, input logic g, input logic y);
    at_side = s; R = r; G = g; Y = y;
  endtask

  task automatic chk_lamps(input string tag, input logic [3:0] r, input logic [3:0] y,
                           input logic [3:0] g);
    chk({tag, ".red"},    {28'd0, lamp_red},    {28'd0, r});
    chk({tag, ".yellow"}, {28'd0, lamp_yellow}, {28'd0, y});
    chk({tag, ".green"},  {28'd0, lamp_green},  {28'd0, g});
  endtask

  initial begin
    reset = 1'b1; fault_clr = 1'b0;
    drive(4'b0000, 1'b1, 1'b0, 1'b0);
    tick(); tick();
    chk("rst.mode", {30'd0, mode}, 32'd0);
    chk_lamps("rst", 4'hF, 4'h0, 4'h0);
    chk("rst.fault", {31'd0, fault}, 32'd0);
    chk("rst.fcnt", {24'd0, fault_count}, 32'd0);

    // Start-up: all red through e8, NORMAL at e8, first update at e9.
    reset = 1'b0;
    drive(4'b0001, 1'b0, 1'b1, 1'b0);
    for (int i = 1; i <= 8; i++) begin
      tick();
      chk($sformatf("init.red.e%0d", i), {28'd0, lamp_red}, 32'hF);
      chk($sformatf("init.mode.e%0d", i), {30'd0, mode}, (i == 8) ? 32'd1 : 32'd0);
    end
    tick();
    chk_lamps("e9", 4'b1110, 4'h0, 4'b0001);

    drive(4'b0100, 1'b0, 1'b0, 1'b1);
    tick();
    chk_lamps("yel", 4'b1011, 4'b0100, 4'h0);
    drive(4'b0000, 1'b1, 1'b0, 1'b0);
    tick();
    chk_lamps("allred", 4'hF, 4'h0, 4'h0);
    chk("allred.fault", {31'd0, fault}, 32'd0);

    // fault_clr outside FLASH does nothing.
    fault_clr = 1'b1;
    tick();
    chk("clr_normal.mode", {30'd0, mode}, 32'd1);
    fault_clr = 1'b0;

    // 2 illegal, 1 legal, 2 illegal: lamps hold, no FLASH.
    drive(4'b0011, 1'b1, 1'b0, 1'b0);
    tick(); tick();
    chk_lamps("ill2", 4'hF, 4'h0, 4'h0);
    chk("ill2.mode", {30'd0, mode}, 32'd1);
    drive(4'b0010, 1'b0, 1'b1, 1'b0);
    tick();
    chk_lamps("legal_mid", 4'b1101, 4'h0, 4'b0010);
    drive(4'b0011, 1'b1, 1'b0, 1'b0);
    tick(); tick();
    chk_lamps("ill2b", 4'b1101, 4'h0, 4'b0010);
    chk("ill2b.mode", {30'd0, mode}, 32'd1);
    chk("ill2b.fault", {31'd0, fault}, 32'd0);
    drive(4'b0010, 1'b0, 1'b1, 1'b0);
    tick();

    // Three G+Y samples trigger FLASH on the third edge.
    drive(4'b0001, 1'b0, 1'b1, 1'b1);
    tick();
    chk("gy1.mode", {30'd0, mode}, 32'd1);
    tick();
    chk("gy2.mode", {30'd0, mode}, 32'd1);
    chk_lamps("gy2", 4'b1101, 4'h0, 4'b0010);
    tick();
    chk("flash.mode", {30'd0, mode}, 32'd2);
    chk("flash.fault", {31'd0, fault}, 32'd1);
    chk("flash.fcnt", {24'd0, fault_count}, 32'd1);
    chk_lamps("flash.entry", 4'h0, 4'hF, 4'h0);
    for (int k = 1; k <= 100; k++) begin
      if (k == 60) drive(4'b0001, 1'b0, 1'b1, 1'b0);
      tick();
      chk($sformatf("flash.y.k%0d", k), {28'd0, lamp_yellow},
          (k < 50 || k >= 100) ? 32'hF : 32'h0);
    end
    chk("flash.hold.mode", {30'd0, mode}, 32'd2);
    chk_lamps("flash.hold", 4'h0, 4'hF, 4'h0);

    // fault_clr with illegal sample is ignored; with legal sample recovers.
    drive(4'b0011, 1'b0, 1'b1, 1'b0);
    fault_clr = 1'b1;
    tick();
    chk("clr_ill.mode", {30'd0, mode}, 32'd2);
    drive(4'b0001, 1'b0, 1'b1, 1'b0);
    tick();
    fault_clr = 1'b0;
    chk("clr.mode", {30'd0, mode}, 32'd0);
    chk("clr.fault", {31'd0, fault}, 32'd0);
    chk("clr.fcnt", {24'd0, fault_count}, 32'd1);
    chk_lamps("clr", 4'hF, 4'h0, 4'h0);
    for (int i = 1; i <= 8; i++) begin
      tick();
      chk($sformatf("rec.red.e%0d", i), {28'd0, lamp_red}, 32'hF);
      chk($sformatf("rec.mode.e%0d", i), {30'd0, mode}, (i == 8) ? 32'd1 : 32'd0);
    end
    tick();
    chk_lamps("rec.e9", 4'b1110, 4'h0, 4'b0001);

    // Second fault, then reset mid-FLASH clears everything.
    drive(4'b1100, 1'b1, 1'b0, 1'b0);
    tick(); tick(); tick();
    chk("f2.mode", {30'd0, mode}, 32'd2);
    chk("f2.fcnt", {24'd0, fault_count}, 32'd2);
    tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst2.mode", {30'd0, mode}, 32'd0);
    chk_lamps("rst2", 4'hF, 4'h0, 4'h0);
    chk("rst2.fault", {31'd0, fault}, 32'd0);
    chk("rst2.fcnt", {24'd0, fault_count}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
